// File: rtl/mux_tree_pkg.sv
// mux_tree_pkg -- shared constants and helpers for the pipelined mux tree.
//   clog2()              : ceiling log2, used to size the select and pipe depth
//   MUX_TREE_MAX_IN      : largest supported input count
//   MUX_TREE_DEF_N_IN    : default input count
//   MUX_TREE_DEF_WIDTH   : default bits per input
// Configuration macro (used by the importing modules): MUX_TREE_PIPE_SEL_CHECK_EN
package mux_tree_pkg;

  localparam int unsigned MUX_TREE_MAX_IN    = 256;
  localparam int unsigned MUX_TREE_DEF_N_IN  = 8;
  localparam int unsigned MUX_TREE_DEF_WIDTH = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// mux_tree_stage -- one registered level of the mux tree.
// Halves the node count: output node j = sel_i[0] ? node 2j+1 : node 2j.
// The consumed select bit is dropped; remaining upper bits travel with the slot.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   adv_i             shift enable (all stages advance together)
//   vld_i/vld_o       slot valid in/out
//   dat_i/dat_o       N_NODES / N_NODES/2 packed data nodes
//   sel_i/sel_o       remaining select bits in / upper bits out
//   err_i/err_o       out-of-range flag (only with MUX_TREE_PIPE_SEL_CHECK_EN)
module mux_tree_stage #(
  parameter  int unsigned N_NODES = 2,
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned SEL_W   = 1,
  localparam int unsigned SO_W    = (SEL_W > 1) ? SEL_W - 1 : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           adv_i,
  input  logic                           vld_i,
  input  logic [N_NODES*WIDTH-1:0]       dat_i,
  input  logic [SEL_W-1:0]               sel_i,
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  input  logic                           err_i,
  output logic                           err_o,
`endif
  output logic                           vld_o,
  output logic [(N_NODES/2)*WIDTH-1:0]   dat_o,
  output logic [SO_W-1:0]                sel_o
);

  localparam int unsigned N_OUT = N_NODES / 2;

  logic                     vld_q;
  logic [N_OUT*WIDTH-1:0]   dat_q;
  logic [N_OUT*WIDTH-1:0]   dat_d;

  always_comb begin
    dat_d = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      dat_d[j*WIDTH +: WIDTH] = sel_i[0] ? dat_i[(2*j+1)*WIDTH +: WIDTH]
                                         : dat_i[(2*j)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (adv_i) begin
      vld_q <= vld_i;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

  // The final level has no select bits left to forward.
  if (SEL_W > 1) begin : g_sel
    logic [SO_W-1:0] sel_q;
    always_ff @(posedge clk) begin
      if (!rst_n)     sel_q <= '0;
      else if (adv_i) sel_q <= sel_i[SEL_W-1:1];
    end
    assign sel_o = sel_q;
  end else begin : g_sel_last
    assign sel_o = '0;
  end

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n)     err_q <= 1'b0;
    else if (adv_i) err_q <= err_i;
  end
  assign err_o = err_q;
`endif

endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe -- pipelined N_IN:1 multiplexer built as a binary tree with a
// register after every level (LVL = clog2(N_IN) stages, LSB select first).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   i [N_IN*WIDTH]       packed inputs, input k at [k*WIDTH +: WIDTH]
//   s [LVL]              select index
//   in_valid / in_ready  input handshake (in_ready = out_ready || !out_valid)
//   y [WIDTH]            selected data (zero when s >= N_IN)
//   out_valid/out_ready  output handshake
//   sel_err              select of current y was out of range
// Configuration: define MUX_TREE_PIPE_SEL_CHECK_EN to enable sel_err; otherwise
// sel_err is tied to 0 and no check logic exists.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int unsigned N_IN  = MUX_TREE_DEF_N_IN,
  parameter int unsigned WIDTH = MUX_TREE_DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   i,
  input  logic [clog2(N_IN)-1:0]  s,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam int unsigned LVL    = clog2(N_IN);
  localparam int unsigned N_LEAF = 1 << LVL;

  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  // Pad missing leaves with zero so out-of-range selects yield zero data.
  logic [N_LEAF*WIDTH-1:0] leaf;
  always_comb begin
    leaf = '0;
    leaf[N_IN*WIDTH-1:0] = i;
  end

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  logic err_in;
  if (N_IN == N_LEAF) begin : g_err_none
    assign err_in = 1'b0;
  end else begin : g_err_cmp
    assign err_in = (32'(s) >= N_IN);
  end
`endif

  for (genvar L = 0; L < LVL; L++) begin : g_lvl
    localparam int unsigned NN  = N_LEAF >> L;
    localparam int unsigned SW  = LVL - L;
    localparam int unsigned SOW = (SW > 1) ? SW - 1 : 1;

    logic                    vld;
    logic [(NN/2)*WIDTH-1:0] dat;
    logic [SOW-1:0]          sel;
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    logic                    err;
`endif

    if (L == 0) begin : g_first
      mux_tree_stage #(
        .N_NODES (NN),
        .WIDTH   (WIDTH),
        .SEL_W   (SW)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (adv),
        .vld_i (in_valid),
        .dat_i (leaf),
        .sel_i (s),
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
        .err_i (err_in),
        .err_o (err),
`endif
        .vld_o (vld),
        .dat_o (dat),
        .sel_o (sel)
      );
    end else begin : g_next
      mux_tree_stage #(
        .N_NODES (NN),
        .WIDTH   (WIDTH),
        .SEL_W   (SW)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (adv),
        .vld_i (g_lvl[L-1].vld),
        .dat_i (g_lvl[L-1].dat),
        .sel_i (g_lvl[L-1].sel),
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
        .err_i (g_lvl[L-1].err),
        .err_o (err),
`endif
        .vld_o (vld),
        .dat_o (dat),
        .sel_o (sel)
      );
    end
  end

  assign y         = g_lvl[LVL-1].dat;
  assign out_valid = g_lvl[LVL-1].vld;
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  assign sel_err   = g_lvl[LVL-1].err;
`else
  assign sel_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe -- self-checking bench for mux_tree_pipe.
// Two instances: default N_IN=8 (dut_a) and N_IN=5 (dut_b). A slot-level
// reference model predicts every output; directed scenarios cover latency,
// streaming, backpressure, bubbles, out-of-range selects and mid-run reset,
// followed by a randomized phase.
// Honours MUX_TREE_PIPE_SEL_CHECK_EN for the expected sel_err.
module tb_mux_tree_pipe;

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] i_a;
  logic [39:0] i_b;
  logic [2:0]  s_a, s_b;
  logic        iv_a, iv_b, ir_a, ir_b, or_a, or_b, ov_a, ov_b, err_a, err_b;
  logic [7:0]  y_a, y_b;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  mux_tree_pipe #(.N_IN(8), .WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .i(i_a), .s(s_a), .in_valid(iv_a),
    .in_ready(ir_a), .y(y_a), .out_valid(ov_a), .out_ready(or_a),
    .sel_err(err_a)
  );

  mux_tree_pipe #(.N_IN(5), .WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .i(i_b), .s(s_b), .in_valid(iv_b),
    .in_ready(ir_b), .y(y_b), .out_valid(ov_b), .out_ready(or_b),
    .sel_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: y is input s if s < n, otherwise zero.
  function automatic logic [7:0] pick(input logic [63:0] bus, input int unsigned n,
                                      input int unsigned sel);
    logic [7:0] r;
    r = 8'h00;
    if (sel < n) r = bus[sel*8 +: 8];
    return r;
  endfunction

  // Model: three in-flight slots per DUT; index 2 is what the output shows.
  typedef struct {
    bit         v;
    logic [7:0] y;
    bit         e;
  } slot_t;

  slot_t ma[3];
  slot_t mb[3];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        ma[k] = '{1'b0, 8'h00, 1'b0};
        mb[k] = '{1'b0, 8'h00, 1'b0};
      end
    end else begin
      if (or_a || !ma[2].v) begin
        ma[2] = ma[1];
        ma[1] = ma[0];
        ma[0] = '{iv_a === 1'b1, pick(i_a, 8, 32'(s_a)), 1'b0};
      end
      if (or_b || !mb[2].v) begin
        mb[2] = mb[1];
        mb[1] = mb[0];
        mb[0] = '{iv_b === 1'b1, pick({24'd0, i_b}, 5, 32'(s_b)),
                  ERR_EN && (s_b >= 3'd5)};
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_in_ready", 32'(ir_a), 32'(or_a || !ma[2].v));
      chk("a_out_valid", 32'(ov_a), 32'(ma[2].v));
      if (ma[2].v) begin
        chk("a_y", 32'(y_a), 32'(ma[2].y));
        chk("a_sel_err", 32'(err_a), 32'(ma[2].e));
      end
      chk("b_in_ready", 32'(ir_b), 32'(or_b || !mb[2].v));
      chk("b_out_valid", 32'(ov_b), 32'(mb[2].v));
      if (mb[2].v) begin
        chk("b_y", 32'(y_b), 32'(mb[2].y));
        chk("b_sel_err", 32'(err_b), 32'(mb[2].e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ma[k] = '{1'b0, 8'h00, 1'b0};
      mb[k] = '{1'b0, 8'h00, 1'b0};
    end
    rst_n = 1'b0;
    iv_a = 1'b0; iv_b = 1'b0; or_a = 1'b1; or_b = 1'b1;
    s_a = '0; s_b = '0;
    for (int k = 0; k < 8; k++) i_a[k*8 +: 8] = 8'(k * 17);
    for (int k = 0; k < 5; k++) i_b[k*8 +: 8] = 8'(8'hA0 + k);

    // Reset
    step();
    step();
    chk("rst_in_ready", 32'(ir_a), 32'd1);
    chk("rst_out_valid", 32'(ov_a), 32'd0);
    chk("rst_y", 32'(y_a), 32'd0);
    chk("rst_sel_err", 32'(err_a), 32'd0);
    chk("rst_b_out_valid", 32'(ov_b), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // Single transfer, exact latency
    iv_a = 1'b1; s_a = 3'd5;
    step();
    iv_a = 1'b0;
    step();
    chk("lat_early_valid", 32'(ov_a), 32'd0);
    step();
    chk("lat_valid", 32'(ov_a), 32'd1);
    chk("lat_y", 32'(y_a), 32'h55);
    chk("lat_err", 32'(err_a), 32'd0);
    step();

    // Streaming s=0..7
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin iv_a = 1'b1; s_a = 3'(c); end
      else iv_a = 1'b0;
      step();
      if (c >= 2 && c - 2 < 8) begin
        chk("stream_valid", 32'(ov_a), 32'd1);
        chk("stream_y", 32'(y_a), 32'((c - 2) * 17));
      end
    end
    chk("stream_drained", 32'(ov_a), 32'd0);

    // Backpressure
    iv_a = 1'b1; s_a = 3'd1; step();
    s_a = 3'd2; step();
    s_a = 3'd3; step();
    chk("bp_first_valid", 32'(ov_a), 32'd1);
    or_a = 1'b0; iv_a = 1'b1; s_a = 3'd7;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("bp_in_ready", 32'(ir_a), 32'd0);
      chk("bp_hold_y", 32'(y_a), 32'h11);
      chk("bp_hold_valid", 32'(ov_a), 32'd1);
      if (c < 3) step();
    end
    step();
    or_a = 1'b1; iv_a = 1'b0;
    #1;
    chk("bp_y1", 32'(y_a), 32'h11);
    step();
    chk("bp_y2", 32'(y_a), 32'h22);
    step();
    chk("bp_y3", 32'(y_a), 32'h33);
    chk("bp_y3_valid", 32'(ov_a), 32'd1);
    step();
    chk("bp_no_dup", 32'(ov_a), 32'd0);

    // Bubbles
    iv_a = 1'b1; s_a = 3'd3; step();
    iv_a = 1'b0; s_a = 3'($urandom); step();
    iv_a = 1'b1; s_a = 3'd7; step();
    iv_a = 1'b0;
    chk("bub_v0", 32'(ov_a), 32'd1);
    chk("bub_y0", 32'(y_a), 32'h33);
    step();
    chk("bub_v1", 32'(ov_a), 32'd0);
    step();
    chk("bub_v2", 32'(ov_a), 32'd1);
    chk("bub_y2", 32'(y_a), 32'h77);
    step();

    // Out-of-range select on N_IN=5
    iv_b = 1'b1; s_b = 3'd6; step();
    s_b = 3'd4; step();
    iv_b = 1'b0; step();
    chk("oor_valid", 32'(ov_b), 32'd1);
    chk("oor_y", 32'(y_b), 32'd0);
    chk("oor_err", 32'(err_b), 32'(ERR_EN));
    step();
    chk("in4_y", 32'(y_b), 32'hA4);
    chk("in4_err", 32'(err_b), 32'd0);
    step();

    // Reset with two results in flight
    iv_a = 1'b1; s_a = 3'd2; step();
    s_a = 3'd6; step();
    iv_a = 1'b0; rst_n = 1'b0; step();
    chk("mrst_valid", 32'(ov_a), 32'd0);
    chk("mrst_y", 32'(y_a), 32'd0);
    chk("mrst_err", 32'(err_a), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mrst_no_stale", 32'(ov_a), 32'd0);
    end

    // Randomized traffic on both instances
    for (int c = 0; c < 800; c++) begin
      iv_a = ($urandom % 4) != 0;
      s_a  = 3'($urandom);
      i_a  = {$urandom, $urandom};
      or_a = ($urandom % 3) != 0;
      iv_b = ($urandom % 4) != 0;
      s_b  = 3'($urandom);
      i_b  = 40'({$urandom, $urandom});
      or_b = ($urandom % 3) != 0;
      rst_n = ($urandom % 97) != 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_tree_pipe.md
MUX_TREE_PIPE -- requirements
Module: mux_tree_pipe

Interface
REQ-001 The block SHALL have parameter N_IN, default 8, giving the number of data inputs; the legal range is 2..256, and the value need not be a power of two.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the bits per data input.
REQ-003 The block SHALL derive LVL = ceil(log2(N_IN)), which is both the select width and the number of pipeline stages.
REQ-004 Clock and reset: the block SHALL have one clock; reset is synchronous and active-low.
REQ-005 Ports SHALL be as follows, in this order:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- i  in  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- s  in  LVL  select index.
- in_valid  in  1  i and s are valid this cycle.
- in_ready  out  1  the block accepts i and s this cycle.
- y  out  WIDTH  selected data.
- out_valid  out  1  y is valid.
- out_ready  in  1  the consumer accepts y.
- sel_err  out  1  the select for the current y was out of range.

Function
REQ-006 An input transfer SHALL occur when in_valid && in_ready, and an output transfer when out_valid && out_ready.
REQ-007 The block SHALL form a binary tree of LVL levels with a register after every level; latency from input transfer to out_valid SHALL be exactly LVL cycles when there are no stalls.
REQ-008 Level L SHALL pair node 2j with node 2j+1 using s[L]: s[L]=0 selects the even node and s[L]=1 selects the odd node. Level 0 SHALL use s[0] (LSB first).
REQ-009 Each stage SHALL carry its valid bit, the unused upper select bits, and the err flag alongside the data.
REQ-010 Stage advance SHALL be adv = out_ready || !out_valid; in_ready SHALL equal adv, combinationally.
REQ-011 When adv=1, all stages SHALL shift together. When adv=0, all stage registers SHALL hold their values and i/s SHALL be ignored.
REQ-012 Bubbles SHALL NOT be collapsed inside the pipe; a cycle with in_valid=0 while adv=1 SHALL insert an invalid slot.
REQ-013 With sustained out_ready=1 and in_valid=1, throughput SHALL be one result per cycle.
REQ-014 When out_valid=1 and out_ready=0, y, sel_err and out_valid SHALL stay stable until the output transfer.
REQ-015 A tree node with no corresponding input (index >= N_IN) SHALL contribute all-zero data.
REQ-016 y SHALL equal input s when s < N_IN, and zero otherwise.
REQ-017 The s and data fields of invalid slots are don't-care, but these fields SHALL never assert out_valid.

Reset
REQ-018 When rst_n=0 at a clock edge, all valid bits, data registers and err flags SHALL clear to 0.
REQ-019 After reset, out_valid=0, y=0 and sel_err=0.
REQ-020 Results in flight when rst_n=0 is sampled SHALL be discarded, and none SHALL emerge after reset.
REQ-021 During reset, in_ready SHALL follow REQ-010, so in_ready=1 because out_valid=0; no transfer is recorded during reset.

Configuration
REQ-022 The configuration macro SHALL be MUX_TREE_PIPE_SEL_CHECK_EN.
- Defined: sel_err SHALL be registered as (s >= N_IN) at input transfer and SHALL travel with the slot.
- Undefined: sel_err SHALL be tied to 0, with no check logic or err registers present; y behaviour is unchanged.
- When N_IN is a power of two, sel_err SHALL be constant 0 in both builds.

Structure
REQ-023 Package mux_tree_pkg SHALL hold:
- the clog2 function;
- MUX_TREE_MAX_IN = 256;
- defaults MUX_TREE_DEF_N_IN = 8 and MUX_TREE_DEF_WIDTH = 8.
REQ-024 Sub-module mux_tree_stage SHALL implement one registered level, parameterised by node count, WIDTH and remaining select width. mux_tree_pipe SHALL instantiate it LVL times in a generate loop.

Verification
REQ-025 Default parameters (N_IN=8, WIDTH=8, LVL=3):
- Stimulus: i = {8'h77,8'h66,...,8'h00}, s=5, out_ready=1.
- Required: y=8'h55 and out_valid=1 exactly 3 cycles after the transfer, sel_err=0.
REQ-026 Streaming with default parameters:
- Stimulus: s=0..7 on consecutive cycles, out_ready=1.
- Required: y=00,11,...,77 in order on 8 consecutive cycles, no gaps.
REQ-027 Backpressure:
- Stimulus: stream s=1,2,3; hold out_ready=0 for 4 cycles once out_valid=1.
- Required: in_ready=0 throughout the stall, y=8'h11 held stable, then 11,22,33 delivered with no loss or duplication.
REQ-028 N_IN=5 with MUX_TREE_PIPE_SEL_CHECK_EN defined:
- s=6 -> y=0 and sel_err=1 after 3 cycles.
- s=4 -> y = input 4 and sel_err=0.
- Without the macro: s=6 -> y=0 and sel_err=0.
REQ-029 Reset mid-operation:
- Stimulus: two transfers in flight, rst_n=0 for one cycle.
- Required: next cycle out_valid=0 and y=0, and no stale result appears in the following 5 cycles.
REQ-030 Bubbles with default parameters:
- Stimulus: in_valid pattern 1,0,1 with s=3,x,7, out_ready=1.
- Required: out_valid pattern 1,0,1 starting at cycle 3, with y=33 and y=77.
